ctech_lib_buf_rx_filt: RTL
==========================

# ctech_lib_buf_rx_filt

Receive-end conditioner for a level signal driven across the die through ctech buffer cells. The block synchronizes the asynchronous level into the local clock domain and deglitches it with a consecutive-cycle qualification counter. It then presents a clean level with single-cycle rise/fall strobes and a saturating glitch counter for debug. It sits at the load end of long buffered control wires, such as straps and wake or enable levels, in front of any logic that must not see runt pulses.

## Interface
- SYNC_STAGES, default 2: number of flops in the metastability chain, minimum 2.
- FILT_CYCLES, default 4: number of consecutive synchronized cycles of disagreement required before `o` changes, minimum 1.
- RST_VAL, default 1'b0: reset value of the sync chain and of `o`.
- clk  input  1  sole clock.
- rst  input  1  reset, asynchronous and active-high. It clears all state immediately; deassertion is synchronous to `clk` and is handled externally.
- a  input  1  asynchronous level from the buffered wire.
- en  input  1  filter enable. When 0, the filter is bypassed.
- clr_cnt  input  1  synchronous clear of `glitch_cnt`.
- o  output  1  filtered, synchronized level.
- o_rise  output  1  one-cycle strobe in the same cycle `o` goes 0→1.
- o_fall  output  1  one-cycle strobe in the same cycle `o` goes 1→0.
- glitch  output  1  one-cycle strobe when a disagreement is abandoned before qualification.
- glitch_cnt  output  8  saturating count of `glitch` events.

## Operation
- Sync chain: `a` is sampled through SYNC_STAGES flops; `s` is the last stage.
- The qualification counter `cnt` is $clog2(FILT_CYCLES+1) bits wide and unsigned.
- State machine states:
  - STABLE: `s`==`o`, `cnt`=0.
  - QUALIFY: `s`!=`o` on the previous sample, 1 ≤ `cnt` < FILT_CYCLES.
- Each edge with en=1, `cnt_nx` = `cnt`+1 when `s`!=`o`.
  - If `cnt_nx`==FILT_CYCLES: `o` <= ~`o`, `cnt` <= 0, go to STABLE. The matching `o_rise` or `o_fall` is asserted for exactly that cycle.
  - Else, if `s`!=`o`: `cnt` <= `cnt_nx`, go to or stay in QUALIFY.
  - Else, in QUALIFY with `s`==`o`: `glitch` <= 1 for one cycle, `cnt` <= 0, go to STABLE.
  - Else: stay in STABLE.
- FILT_CYCLES=1: `o` flips on the first disagreeing sample. QUALIFY is never entered and `glitch` never fires.
- en=0 (bypass):
  - `o` <= `s` each edge, and edge strobes are still generated.
  - `cnt` is held at 0 and the state is forced to STABLE.
  - `glitch` stays 0.
- en falling while in QUALIFY: abandon without a `glitch` pulse; `o` <= `s` on that edge.
- `glitch_cnt`:
  - Increments on each `glitch` and saturates at 255, with no wrap.
  - `clr_cnt` sets it to 0. If `clr_cnt` and a `glitch` occur in the same cycle, clear wins and the result is 0.
- Reset value of every output: `o`=RST_VAL; `o_rise`=0, `o_fall`=0, `glitch`=0, `glitch_cnt`=0. Sync chain=RST_VAL, `cnt`=0, state STABLE.
- Reset mid-QUALIFY: the partial count is discarded and no strobe is emitted, during or after reset.

## Timing
- All outputs are registered, so there is no combinational path from any input to any output.
- Latency from an `a` transition (meeting setup) to `o` changing is SYNC_STAGES + FILT_CYCLES edges when en=1, and SYNC_STAGES + 1 edges when en=0.
- Strobes (`o_rise`, `o_fall`, `glitch`) are high for exactly one cycle, coincident with the register update that causes them.
- `glitch_cnt` reflects a glitch on the edge after that glitch's strobe cycle.
- Minimum rejected pulse: a disagreement lasting fewer than FILT_CYCLES synchronized samples is rejected.
- `a` pulses shorter than one `clk` period may be missed entirely; this is not a violation.

## Test plan
- Reset with SYNC_STAGES=2, FILT_CYCLES=4, RST_VAL=0: hold rst=1 and a=1 for 5 cycles. Required: `o`=0, all strobes 0, `glitch_cnt`=0 throughout.
- Clean rise, en=1: set `a` 0→1 and hold. Required:
  - `o` rises on the 6th edge after the change.
  - `o_rise`=1 for exactly that one cycle.
  - `glitch` stays 0.
- Runt pulse, en=1: drive `a`=1 for 2 cycles, then back to 0. Required: `o` stays 0, `glitch` pulses once, `glitch_cnt`=1.
- Saturation and clear: generate 300 runt pulses. Required:
  - `glitch_cnt`=255.
  - Asserting `clr_cnt` in the same cycle as a glitch strobe gives `glitch_cnt`=0 on the next edge.
- Bypass, en=0: toggle `a` 0→1→0 with 5 cycles per level. Required:
  - `o` follows each change 3 edges later.
  - `o_rise` and `o_fall` each pulse once.
  - `glitch`=0.
- Reset mid-QUALIFY: drive `a`=1 for 4 cycles, then assert rst for 1 cycle while `cnt`=2. Required:
  - `o`=0 immediately and no `o_rise` on any later edge.
  - After release, with `a` held at 1, `o` rises after a full 6 edges.

Source files
------------

// File: rtl/ctech_lib_buf_rx_filt.sv
// rtl/ctech_lib_buf_rx_filt.sv - synchronizer, deglitch filter and edge/glitch strobes for a buffered level
module ctech_lib_buf_rx_filt #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       en,
  input  logic       clr_cnt,
  output logic       o,
  output logic       o_rise,
  output logic       o_fall,
  output logic       glitch,
  output logic [7:0] glitch_cnt
);

  localparam int CW = (FILT_CYCLES < 1) ? 1 : $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] FILT_Q = CW'(FILT_CYCLES);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nx;
  logic [CW-1:0]          w_cnt_inc;
  logic                   r_o;
  logic                   w_o_nx;
  logic                   r_rise;
  logic                   w_rise_nx;
  logic                   r_fall;
  logic                   w_fall_nx;
  logic                   r_glitch;
  logic                   w_glitch_nx;
  logic [7:0]             r_glitch_cnt;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign o          = r_o;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign glitch     = r_glitch;
  assign glitch_cnt = r_glitch_cnt;

  // Metastability chain: a enters at stage 0, the last stage is the usable sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a};
    end
  end

  // Qualification decisions: bypass, flip on a full run of disagreement, or abandon a short run.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_o_nx      = r_o;
    w_rise_nx   = 1'b0;
    w_fall_nx   = 1'b0;
    w_glitch_nx = 1'b0;
    if (!en) begin
      // Bypass also silently drops any run in progress; no glitch is reported for it.
      w_state_nx = ST_STABLE;
      w_cnt_nx   = '0;
      w_o_nx     = w_s;
      w_rise_nx  = w_s & ~r_o;
      w_fall_nx  = ~w_s & r_o;
    end else if (w_s != r_o) begin
      if (w_cnt_inc == FILT_Q) begin
        w_state_nx = ST_STABLE;
        w_cnt_nx   = '0;
        w_o_nx     = ~r_o;
        w_rise_nx  = ~r_o;
        w_fall_nx  = r_o;
      end else begin
        w_state_nx = ST_QUALIFY;
        w_cnt_nx   = w_cnt_inc;
      end
    end else if (r_state == ST_QUALIFY) begin
      w_state_nx  = ST_STABLE;
      w_cnt_nx    = '0;
      w_glitch_nx = 1'b1;
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_STABLE;
      r_cnt    <= '0;
      r_o      <= RST_VAL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_o      <= w_o_nx;
      r_rise   <= w_rise_nx;
      r_fall   <= w_fall_nx;
      r_glitch <= w_glitch_nx;
    end
  end

  // Saturating debug count of glitch strobes; a clear overrides a coincident strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glitch_cnt <= 8'd0;
    end else if (clr_cnt) begin
      r_glitch_cnt <= 8'd0;
    end else if (r_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

endmodule
